// File: rtl/disp_pkg.sv
// Shared display definitions: display-mux state codes, nibble codes and
// active-low seven-segment patterns (bit 0 = segment a, bit 6 = segment g).
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_PLAY      = 2'd2,
        ST_GAMEOVER  = 2'd3
    } disp_state_e;

    localparam logic [3:0] NIB_BLANK = 4'hF;
    localparam logic [3:0] NIB_CH_C  = 4'hC;
    localparam logic [3:0] NIB_CH_D  = 4'hD;
    localparam logic [3:0] NIB_CH_E  = 4'hE;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low seven-segment decoder; 4'hF is blank.
module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_nib)
            4'h0:     o_seg = SEG_0;
            4'h1:     o_seg = SEG_1;
            4'h2:     o_seg = SEG_2;
            4'h3:     o_seg = SEG_3;
            4'h4:     o_seg = SEG_4;
            4'h5:     o_seg = SEG_5;
            4'h6:     o_seg = SEG_6;
            4'h7:     o_seg = SEG_7;
            4'h8:     o_seg = SEG_8;
            4'h9:     o_seg = SEG_9;
            4'hA:     o_seg = SEG_A;
            4'hB:     o_seg = SEG_B;
            NIB_CH_C: o_seg = SEG_C;
            NIB_CH_D: o_seg = SEG_D;
            NIB_CH_E: o_seg = SEG_E;
            default:  o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Eight-digit common-anode scanner: per-frame input snapshot, anti-ghost
// dead time, brightness duty window, per-digit blink, registered pin drive.
module seven_seg_scanner
    import disp_pkg::*;
#(
    parameter int unsigned TICKS_PER_DIGIT = 100_000,
    parameter int unsigned BLANK_TICKS     = 16,
    parameter int unsigned BLINK_FRAMES    = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] display_data,
    input  logic [7:0]  blink_mask,
    input  logic [2:0]  brightness,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int unsigned TW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned PW = 40;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_DIGIT - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [PW-1:0] BLANK_W    = PW'(BLANK_TICKS);
    localparam logic [PW-1:0] SPAN_W     = PW'(TICKS_PER_DIGIT - BLANK_TICKS);

    logic [TW-1:0] r_tick;
    logic [2:0]    r_digit;
    logic [FW-1:0] r_frame;
    logic          r_blink_phase;
    logic [31:0]   r_data;
    logic [7:0]    r_mask;
    logic [2:0]    r_bright;
    logic [7:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_frame_start;

    logic          w_tick_wrap;
    logic          w_digit_wrap;
    logic          w_frame_wrap;
    logic [3:0]    w_nib;
    logic [6:0]    w_seg;
    logic [PW-1:0] w_tick_w;
    logic [PW-1:0] w_win_end;
    logic          w_lit;

    assign w_tick_wrap  = (r_tick == TICK_LAST);
    assign w_digit_wrap = w_tick_wrap && (r_digit == 3'd7);
    assign w_frame_wrap = w_digit_wrap && (r_frame == FRAME_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick        <= '0;
            r_digit       <= '0;
            r_frame       <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_tick <= w_tick_wrap ? '0 : r_tick + 1'b1;
            if (w_tick_wrap)
                r_digit <= r_digit + 3'd1;
            if (w_digit_wrap)
                r_frame <= (r_frame == FRAME_LAST) ? '0 : r_frame + 1'b1;
            if (w_frame_wrap)
                r_blink_phase <= ~r_blink_phase;
        end
    end

    // Captured on the last cycle of a frame so the next frame sees one consistent view.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data   <= '1;
            r_mask   <= '0;
            r_bright <= 3'd7;
        end else if (w_digit_wrap) begin
            r_data   <= display_data;
            r_mask   <= blink_mask;
            r_bright <= brightness;
        end
    end

    assign w_nib = r_data[{r_digit, 2'b00} +: 4];

    seg7_decode u_decode (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    // Duty window end is formed at full width before the divide-by-8 shift.
    assign w_tick_w  = PW'(r_tick);
    assign w_win_end = BLANK_W + (((PW'(r_bright) + PW'(1)) * SPAN_W) >> 3);
    assign w_lit     = (w_tick_w >= BLANK_W) && (w_tick_w < w_win_end) &&
                       (w_nib != NIB_BLANK) && !(r_blink_phase && r_mask[r_digit]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an          <= '1;
            r_seg         <= SEG_OFF;
            r_frame_start <= 1'b0;
        end else begin
            r_an          <= w_lit ? ~(8'b1 << r_digit) : '1;
            r_seg         <= w_lit ? w_seg : SEG_OFF;
            r_frame_start <= (r_digit == 3'd0) && (r_tick == '0);
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign dp          = 1'b1;
    assign frame_start = r_frame_start;

endmodule
